// File: rtl/packet_rr_arbiter_2to1.sv
// Two-input Avalon-ST packet arbiter: round-robin grant locked from sop to eop, registered output.
// Optional macro PKT_ARB_CHANNEL_EN adds aso_out0_channel carrying the source index.
module packet_rr_arbiter_2to1 #(
  parameter int DATA_W = 17
) (
  input  logic              clock_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] asi_in0_data,
  input  logic              asi_in0_valid,
  input  logic              asi_in0_startofpacket,
  input  logic              asi_in0_endofpacket,
  output logic              asi_in0_ready,
  input  logic [DATA_W-1:0] asi_in1_data,
  input  logic              asi_in1_valid,
  input  logic              asi_in1_startofpacket,
  input  logic              asi_in1_endofpacket,
  output logic              asi_in1_ready,
  output logic [DATA_W-1:0] aso_out0_data,
  output logic              aso_out0_valid,
  output logic              aso_out0_startofpacket,
  output logic              aso_out0_endofpacket,
  input  logic              aso_out0_ready,
  output logic              aso_out0_empty,
`ifdef PKT_ARB_CHANNEL_EN
  output logic [0:0]        aso_out0_channel,
`endif
  output logic [7:0]        drop_count
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_r, state_s;
  logic              grant_r, grant_s;
  logic              last_grant_r, last_grant_s;
  logic [1:0]        req_s, orphan_s, ready_s;
  logic              win_s, out_free_s, load_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              sel_valid_s, sel_sop_s, sel_eop_s;
  logic [8:0]        drop_sum_s;
  logic [7:0]        drop_next_s;

  assign req_s       = {asi_in1_valid & asi_in1_startofpacket, asi_in0_valid & asi_in0_startofpacket};
  assign orphan_s    = {asi_in1_valid & ~asi_in1_startofpacket, asi_in0_valid & ~asi_in0_startofpacket};
  assign out_free_s  = ~aso_out0_valid | aso_out0_ready;
  assign sel_data_s  = grant_r ? asi_in1_data : asi_in0_data;
  assign sel_valid_s = grant_r ? asi_in1_valid : asi_in0_valid;
  assign sel_sop_s   = grant_r ? asi_in1_startofpacket : asi_in0_startofpacket;
  assign sel_eop_s   = grant_r ? asi_in1_endofpacket : asi_in0_endofpacket;

  // Ready has zero latency so it stays combinational; held low while in reset.
  assign asi_in0_ready  = ready_s[0] & ~reset_reset;
  assign asi_in1_ready  = ready_s[1] & ~reset_reset;
  assign aso_out0_empty = 1'b0;

  // Round-robin winner: the input after last_grant has priority.
  always_comb begin
    win_s = 1'b0;
    if (last_grant_r == 1'b1) begin
      win_s = req_s[0] ? 1'b0 : 1'b1;
    end else begin
      win_s = req_s[1] ? 1'b1 : 1'b0;
    end
  end

  // Next-state, grant lock, handshake and orphan-drop decode.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    ready_s      = 2'b00;
    load_s       = 1'b0;
    drop_sum_s   = {1'b0, drop_count};
    case (state_r)
      IDLE: begin
        ready_s    = orphan_s;
        drop_sum_s = {1'b0, drop_count} + {8'd0, orphan_s[0]} + {8'd0, orphan_s[1]};
        if (req_s != 2'b00) begin
          grant_s = win_s;
          state_s = LOCKED;
        end else begin
          state_s = IDLE;
        end
      end
      LOCKED: begin
        if (grant_r == 1'b0) begin
          ready_s = {1'b0, out_free_s};
        end else begin
          ready_s = {out_free_s, 1'b0};
        end
        load_s = sel_valid_s & out_free_s;
        if (load_s && sel_eop_s) begin
          state_s      = IDLE;
          last_grant_s = grant_r;
        end else begin
          state_s = LOCKED;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Saturate the drop counter at 255.
  always_comb begin
    if (drop_sum_s > 9'd255) begin
      drop_next_s = 8'd255;
    end else begin
      drop_next_s = drop_sum_s[7:0];
    end
  end

  // Control state and registered output stage.
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state_r                <= IDLE;
      grant_r                <= 1'b0;
      last_grant_r           <= 1'b1;
      aso_out0_data          <= '0;
      aso_out0_valid         <= 1'b0;
      aso_out0_startofpacket <= 1'b0;
      aso_out0_endofpacket   <= 1'b0;
      drop_count             <= 8'd0;
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      drop_count   <= drop_next_s;
      if (load_s) begin
        aso_out0_data          <= sel_data_s;
        aso_out0_valid         <= 1'b1;
        aso_out0_startofpacket <= sel_sop_s;
        aso_out0_endofpacket   <= sel_eop_s;
      end else if (aso_out0_valid && aso_out0_ready) begin
        aso_out0_valid         <= 1'b0;
        aso_out0_startofpacket <= 1'b0;
        aso_out0_endofpacket   <= 1'b0;
      end
    end
  end

`ifdef PKT_ARB_CHANNEL_EN
  // Channel travels with the data word it describes.
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      aso_out0_channel <= 1'b0;
    end else if (load_s) begin
      aso_out0_channel <= grant_r;
    end
  end
`endif

endmodule

// File: doc/packet_rr_arbiter_2to1.md
# packet_rr_arbiter_2to1

Two-input Avalon-ST packet arbiter that shares one downstream packet sink (the 17-bit complex-sample stream feeding the FFT path) between two fixed-length byte-to-packet framers. Grants are round-robin and locked for a whole packet, from the accepted startofpacket beat through the accepted endofpacket beat. The output is a registered stage with full-throughput backpressure.

## Interface
- DATA_W, 17, beat width; matches framer output {real[7:0], imag[7:0], 1'b1}.
- clock_clk  in  1  single clock; all logic on rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- asi_in0_data  in  DATA_W  sink 0 beat data.
- asi_in0_valid / asi_in0_startofpacket / asi_in0_endofpacket  in  1 each  sink 0 qualifiers.
- asi_in0_ready  out  1  sink 0 ready (ready latency 0).
- asi_in1_data, asi_in1_valid, asi_in1_startofpacket, asi_in1_endofpacket, asi_in1_ready: same as sink 0, for input 1.
- aso_out0_data  out  DATA_W  registered output beat.
- aso_out0_valid / aso_out0_startofpacket / aso_out0_endofpacket  out  1 each  registered qualifiers.
- aso_out0_ready  in  1  downstream ready (ready latency 0).
- aso_out0_empty  out  1  constant 0.
- drop_count  out  8  saturating count of discarded orphan beats.

## Operation
- State: IDLE or LOCKED. Grant register g is 1 bit. last_grant is 1 bit.
- IDLE:
  - Requests are req[i] = asi_in{i}_valid & asi_in{i}_startofpacket.
  - Priority goes to input (last_grant+1) mod 2; the other input wins if it is the only requester.
  - On any request: g <= winner, state <= LOCKED. No beat is accepted in the IDLE cycle.
  - Orphan beats (valid without startofpacket) on either input: ready=1 and the beat is discarded. drop_count increments by the number of orphans that cycle (0, 1 or 2), saturating at 255.
  - Inputs carrying a request see ready=0.
- LOCKED:
  - asi_in{g}_ready = !aso_out0_valid | aso_out0_ready. The non-granted input has ready=0.
  - Accepted beat (valid & ready on input g) loads aso_out0_data/sop/eop and sets aso_out0_valid=1.
  - Accepted beat with endofpacket: state <= IDLE, last_grant <= g.
  - A startofpacket inside a locked packet passes through unchanged; the lock is held until eop.
- Output register: when aso_out0_valid & aso_out0_ready and no new beat loads, aso_out0_valid/sop/eop clear to 0. Data holds its value.
- Reset values: state IDLE, last_grant=1 (input 0 wins first tie), g=0, aso_out0_valid/sop/eop=0, aso_out0_data=0, drop_count=0, both asi ready=0 during reset.
- Reset mid-packet: the packet is aborted. No eop is emitted, the output valid drops the next cycle, and the partial packet is lost.

## Timing
- First beat of a packet: sop valid in cycle t (IDLE) -> LOCKED in t+1 -> accepted at end of t+1 -> aso_out0_valid=1 in t+2 (2-cycle latency).
- Within a packet: 1 beat per cycle while aso_out0_ready=1. Latency is 1 cycle.
- Packet-to-packet gap: eop accepted at end of k -> IDLE in k+1 -> next first beat accepted at end of k+2 -> aso_out0_valid is low for exactly one cycle between packets (k+2).
- Backpressure: aso_out0_ready=0 with the output full holds the output register and deasserts asi_in{g}_ready in the same cycle, with no data loss.
- Simultaneous requests in IDLE: resolved in one cycle by last_grant; the loser keeps ready=0 and keeps its sop beat presented.

## Configuration
- PKT_ARB_CHANNEL_EN:
  - Defined: adds output aso_out0_channel [0:0]. It is registered alongside aso_out0_data with the value g, reset value 0.
  - Undefined: the port does not exist, and the rest of the behaviour is identical.

## Test plan
- Reset then single source: input 0 sends a 4-beat packet (sop on beat 0, eop on beat 3), ready held 1 -> output beats appear in cycles t+2..t+5 with sop/eop aligned, drop_count=0.
- Contention: both inputs present sop in the same cycle after reset -> input 0 is granted first (full packet), then input 1, then input 0. No interleaving; a one-cycle valid gap between packets.
- Backpressure: aso_out0_ready toggles 1,0,0,1 mid-packet -> no beat lost or duplicated, and asi ready tracks the rule exactly.
- Orphans: input 1 drives 3 valid beats without sop while IDLE -> all three accepted and discarded, drop_count=3. Then 300 orphans -> drop_count saturates at 255.
- Reset mid-packet: assert reset_reset after beat 2 of 6 -> next cycle all outputs are 0 and state is IDLE. A new packet from input 0 is then granted normally (last_grant=1).
- With PKT_ARB_CHANNEL_EN: alternating packets -> aso_out0_channel equals the source index on every output beat.
